// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, state encoding and row types for the systolic array memories
package systolic_pkg;
    localparam int BITS_C     = 32;
    localparam int DIM        = 8;
    localparam int CAP_CYCLES = 2 * DIM - 1;
    localparam int CNT_W      = $clog2(2 * DIM);
    localparam int ROW_W      = $clog2(DIM);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} drain_state_t;
    typedef logic signed [BITS_C-1:0] c_elem_t;
    typedef c_elem_t [DIM-1:0] c_row_t;
endpackage

// File: rtl/memc_skew_buf.sv
// memc_skew_buf: DIMxDIM result buffer that de-skews south-edge columns, one read row
module memc_skew_buf
    import systolic_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [CNT_W-1:0] cap_cnt_i,
    input  c_row_t           wr_data_i,
    input  logic [ROW_W-1:0] rd_row_i,
    output c_row_t           rd_data_o
);
    c_row_t mem_q [DIM];
    // column j carries row cap_cnt-j this cycle; write only while that row lies inside the array
    always_ff @(posedge clk) begin
        for (int j = 0; j < DIM; j++) begin
            if (we_i && cap_cnt_i >= CNT_W'(j) && (cap_cnt_i - CNT_W'(j)) < CNT_W'(DIM))
                mem_q[ROW_W'(cap_cnt_i - CNT_W'(j))][j] <= wr_data_i[j];
        end
    end
    assign rd_data_o = mem_q[rd_row_i];
endmodule

// File: rtl/memc_drain.sv
// memc_drain: captures skewed C results from the array and streams them to the host row by row
module memc_drain
    import systolic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_start,
    input  c_row_t           Cin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last,
    output c_row_t           Cout
);
    drain_state_t     state_q, state_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    c_row_t           rd_data;
    memc_skew_buf u_buf (
        .clk       (clk),
        .we_i      (state_q == CAPTURE),
        .cap_cnt_i (cap_cnt_q),
        .wr_data_i (Cin),
        .rd_row_i  (row_q),
        .rd_data_o (rd_data)
    );
    // state, capture counter and drain row registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cap_cnt_q <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            cap_cnt_q <= cap_cnt_d;
            row_q     <= row_d;
        end
    end
    // capture runs a fixed window, drain advances one row per accepted handshake
    always_comb begin
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        row_d     = row_q;
        case (state_q)
            IDLE: begin
                cap_cnt_d = '0;
                row_d     = '0;
                if (cap_start) state_d = CAPTURE;
            end
            CAPTURE: begin
                cap_cnt_d = cap_cnt_q + 1'b1;
                if (cap_cnt_q == CNT_W'(CAP_CYCLES - 1)) begin
                    state_d   = DRAIN;
                    cap_cnt_d = '0;
                    row_d     = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_W'(DIM - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DRAIN;
    assign out_row   = row_q;
    assign out_last  = out_valid && row_q == ROW_W'(DIM - 1);
    assign Cout      = out_valid ? rd_data : '0;
endmodule

// File: doc/memc_drain.md
Name: memc_drain

Overview:
- Result-side counterpart of the A-operand preload memory for the DIMxDIM systolic array.
- The A side de-serialises host rows into skewed per-row FIFOs feeding the array. This block does the reverse: it captures the skewed C results leaving the array's south edge, de-skews them into a DIMxDIM buffer, and streams them back to the host one row per handshake.
- It sits between the array's south-edge outputs and the host/AFU result path.

Parameters:
- BITS_C, 32, width of one signed C element.
- DIM, 8, array dimension: rows, columns and elements per output row.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_start  in  1  one-cycle pulse: array drain begins next cycle.
- Cin  in  DIM x BITS_C signed  south-edge outputs; Cin[j] is column j.
- busy  out  1  high in CAPTURE or DRAIN.
- out_valid  out  1  Cout/out_row hold a valid row.
- out_ready  in  1  host accepts the row when out_valid && out_ready.
- out_row  out  $clog2(DIM)  index of the row on Cout.
- out_last  out  1  high with out_valid when out_row == DIM-1.
- Cout  out  DIM x BITS_C signed  row data; Cout[j] = C[out_row][j].

Behaviour:
- Reset values: busy=0, out_valid=0, out_row=0, out_last=0, Cout=0. FSM=IDLE, counters=0.
- Buffer contents are not cleared by reset; they are never exposed while out_valid=0.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - cap_start=1 at edge t0 -> CAPTURE, cap_cnt=0.
  - Otherwise stay in IDLE.
- CAPTURE:
  - Input skew contract: element C[r][j] is on Cin[j] during the cycle with cap_cnt == r+j.
  - On each edge, for every column j with 0 <= cap_cnt-j <= DIM-1, write buf[cap_cnt-j][j] <= Cin[j]. Other columns are not written.
  - cap_cnt increments each cycle. At cap_cnt == 2*DIM-2, the write occurs and the FSM moves to DRAIN with drain row=0.
  - CAPTURE lasts exactly 2*DIM-1 cycles. For DIM=8, Cin is sampled at the edges ending cycles t0+1..t0+15.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle, i.e. cycle t0+2*DIM (t0+16 for DIM=8).
  - Cout = buf[out_row], out_last = (out_row == DIM-1).
  - Handshake: a transfer occurs on an edge with out_valid && out_ready.
  - Without a transfer, out_row, Cout and out_last hold stable; no back-pressure timeout.
  - Transfer with out_row < DIM-1: out_row increments and the next row is valid the following cycle. Full throughput is one row per cycle.
  - Transfer with out_row == DIM-1: -> IDLE. out_valid, out_last and out_row drop to 0 on that edge.
- cap_start while busy=1 is ignored and does not restart or corrupt the operation.
- cap_start in the cycle that DRAIN->IDLE happens is ignored; host must re-pulse.
- rst during any state forces the reset values on the next edge; a partial capture is discarded.
- No arithmetic; elements pass bit-exact, sign preserved.
- Cout is driven from the buffer through a row mux (combinational from registered out_row); no extra latency.
- DIM must be a power of two >= 2. Counter cap_cnt is $clog2(2*DIM) bits.

Decomposition:
- Shared package systolic_pkg:
  - BITS_C and DIM defaults.
  - drain_state_t enum {IDLE, CAPTURE, DRAIN}.
  - localparam CAP_CYCLES = 2*DIM-1.
  - Typedef c_row_t: an array of DIM signed BITS_C elements.
- One natural sub-module, memc_skew_buf: DIMxDIM register array with per-column write enable and row index computed from cap_cnt. It has one read port selected by out_row.
- The FSM, counters and handshake live in memc_drain.

Test Plan:
- Basic de-skew (DIM=8): pulse cap_start at t0; drive Cin[j] = 100*r + j during cycle t0+1+r+j and 32'hDEAD_BEEF outside each element's window; hold out_ready=1.
  -> out_valid rises at t0+16; rows 0..7 appear on consecutive cycles with Cout[j] = 100*r + j; out_last only on row 7; busy=0 at t0+24.
- Back-pressure: same capture, out_ready = 1,0,0,1 repeating.
  -> each row is held stable while out_ready=0; exactly 8 transfers occur, in order; out_row never skips or repeats after a transfer.
- Signed data: C[r][j] = -(r*8 + j + 1), e.g. 32'hFFFF_FFFF for element (0,0).
  -> values return bit-exact; C[7][7] reads as -64.
- Ignored start: pulse cap_start at t0+5 during CAPTURE and at t0+18 during DRAIN.
  -> timing and data are identical to scenario 1; no second capture occurs.
- Reset mid-operation: assert rst at t0+7 for one cycle.
  -> next cycle busy=0, out_valid=0, out_row=0, Cout=0; a fresh cap_start afterwards produces a correct full result.
- Back-to-back jobs: complete one drain, then pulse cap_start the cycle after busy=0 with new data Cin = 1000 + 100*r + j.
  -> the second job returns only the new values; no stale rows from job 1.
